// File: rtl/dmem_responder.sv
// dmem_responder: slow data-memory responder with programmable wait states and one-cycle valid pulse.
//   Ports: clk, rst (async active-low); request/we_re/load/address/data_in/mask in;
//   valid (completion pulse), data_out (load data), busy (not IDLE) out.
//   Optional macro DMEM_RESP_STATS_EN adds saturating rd_count/wr_count outputs.
module dmem_responder #(
   parameter int ADDR_W  = 8,
   parameter int LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              request,
   input  logic              we_re,
   input  logic              load,
   input  logic [ADDR_W-1:0] address,
   input  logic [31:0]       data_in,
   input  logic [3:0]        mask,
   output logic              valid,
   output logic [31:0]       data_out,
   output logic              busy
`ifdef DMEM_RESP_STATS_EN
   ,
   output logic [15:0]       rd_count,
   output logic [15:0]       wr_count
`endif
);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic                we_q, we_d, load_q, load_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d, data_out_q, data_out_d;
   logic [3:0]          mask_q, mask_d;
   logic                enter_resp, rd_en;
   logic [31:0]         lane, rd_word;
   logic [31:0]         mem [2**ADDR_W];
`ifdef DMEM_RESP_STATS_EN
   logic [15:0]         rd_count_q, rd_count_d, wr_count_q, wr_count_d;
`endif
   // The *_d fields hold the transaction being served: fresh inputs on the accept edge,
   // the captured copy afterwards, so LATENCY=1 commits without waiting for the capture.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      load_d  = load_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      mask_d  = mask_q;
      case (state_q)
         IDLE: if (request) begin
            we_d    = we_re;
            load_d  = load;
            addr_d  = address;
            wdata_d = data_in;
            mask_d  = mask;
            cnt_d   = 4'(LATENCY - 1);
            state_d = (LATENCY > 1) ? WAIT : RESP;
         end
         WAIT: begin
            cnt_d   = cnt_q - 4'd1;
            state_d = (cnt_q == 4'd1) ? RESP : WAIT;
         end
         default: state_d = IDLE;
      endcase
      enter_resp = (state_d == RESP) && (state_q != RESP);
      rd_en      = !we_d && load_d;
      lane       = {{8{mask_d[3]}}, {8{mask_d[2]}}, {8{mask_d[1]}}, {8{mask_d[0]}}};
      rd_word    = mem[addr_d];
      data_out_d = enter_resp ? (rd_en ? (rd_word & lane) : 32'h0) : data_out_q;
`ifdef DMEM_RESP_STATS_EN
      rd_count_d = (enter_resp && rd_en && !(&rd_count_q)) ? rd_count_q + 16'd1 : rd_count_q;
      wr_count_d = (enter_resp && we_d && !(&wr_count_q)) ? wr_count_q + 16'd1 : wr_count_q;
`endif
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         we_q       <= 1'b0;
         load_q     <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= 32'h0;
         mask_q     <= 4'h0;
         data_out_q <= 32'h0;
`ifdef DMEM_RESP_STATS_EN
         rd_count_q <= 16'h0;
         wr_count_q <= 16'h0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         we_q       <= we_d;
         load_q     <= load_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         mask_q     <= mask_d;
         data_out_q <= data_out_d;
`ifdef DMEM_RESP_STATS_EN
         rd_count_q <= rd_count_d;
         wr_count_q <= wr_count_d;
`endif
      end
   end
   // Array is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (enter_resp && we_d)
         for (int i = 0; i < 4; i++)
            if (mask_d[i]) mem[addr_d][8*i +: 8] <= wdata_d[8*i +: 8];
   end
   assign valid    = (state_q == RESP);
   assign busy     = (state_q != IDLE);
   assign data_out = data_out_q;
`ifdef DMEM_RESP_STATS_EN
   assign rd_count = rd_count_q;
   assign wr_count = wr_count_q;
`endif
endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the core's data-memory request/valid handshake (`request`, `we_re`, `mask`, `load`, word `address`, `valid`, `data_out`).
- Accepts one word-addressed load or store at a time.
- Inserts a programmable number of wait states, then signals completion with a one-cycle `valid` pulse.
- Used in place of the fixed-latency data memory to exercise core stall logic under slow memory.

Parameters:
- ADDR_W, 8, word-address width; array depth is 2**ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to the `valid` pulse; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  one clock; reset is asynchronous and active-low.
- request  input  1  single-cycle transaction strobe from the core.
- we_re  input  1  1 = store, 0 = load; sampled with `request`.
- load  input  1  qualifies a load; a read is performed only when `we_re`=0 and `load`=1.
- address  input  ADDR_W  word address, e.g. `alu_out_address[ADDR_W+1:2]`.
- data_in  input  32  store data, byte lanes already aligned.
- mask  input  4  byte-lane enables; bit i covers `data[8i+7:8i]`.
- valid  output  1  one-cycle completion pulse.
- data_out  output  32  load data; meaningful only while `valid`=1.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (`rst`=0, asynchronous):
  - FSM goes to IDLE; `valid`=0, `busy`=0, `data_out`=32'h0, wait counter = 0, captured fields = 0.
  - Array contents are not cleared and are retained across reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If `request`=1, capture `we_re`, `load`, `address`, `data_in` and `mask` into registers.
  - Load counter with LATENCY-1.
  - Go to WAIT if LATENCY>1, else go to RESP.
- WAIT: decrement counter each cycle; when counter reaches 1, go to RESP next cycle.
- RESP (exactly one cycle):
  - `valid`=1, then return to IDLE.
- Latency: with `request` high at edge N, `valid` is high during cycle N+LATENCY.
- Store:
  - Committed on the edge that enters RESP, using the captured values.
  - Only bytes with `mask` bit = 1 are written; other bytes keep their old values.
  - A mask of 4'b0000 is a legal no-op write that still produces `valid`.
  - During a store response `data_out` is 32'h0.
- Load:
  - On entering RESP, `data_out` is set to the array word AND-ed per byte with the expanded mask; unmasked lanes read 0.
  - `data_out` holds its value after `valid` drops, until the next response.
  - Sign or zero extension is the core's job, not this block's.
- Request with `we_re`=0 and `load`=0: treated as a null transaction; still completes with `valid` and `data_out`=32'h0.
- `request` while `busy`=1 (including the RESP cycle) is ignored: no queueing, no error flag.
- The earliest new acceptance is the cycle after RESP.
- Address is always in range by construction (ADDR_W bits); no wrap logic is required.
- Reset asserted mid-transaction:
  - The transaction is aborted and no `valid` is issued.
  - If reset arrives before the commit edge, the store is not committed.

Optional Feature:
- Macro: `DMEM_RESP_STATS_EN`.
- When defined, add two outputs:
  - `rd_count` [15:0]: increments on each load response.
  - `wr_count` [15:0]: increments on each store response, including mask-0 stores.
  - Both saturate at 16'hFFFF, reset to 0, and null transactions count in neither.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Store then load, LATENCY=2:
  - Store addr 8'h10, data 32'hDEADBEEF, mask 4'hF; `valid` must pulse exactly 2 cycles after `request`.
  - Load addr 8'h10, mask 4'hF -> `data_out`=32'hDEADBEEF with `valid`.
- Byte-masked store:
  - Preload 32'h11223344 at 8'h20; store 32'hAABBCCDD with mask 4'b0101.
  - Load mask 4'hF -> 32'h11BB33DD.
  - Load mask 4'b0010 -> 32'h0000_3300.
- Ignored request: pulse a second `request` (store 32'h5 to 8'h30) while `busy`=1 -> only one `valid` is issued and a later load of 8'h30 does not return 32'h5.
- LATENCY=1 back-to-back:
  - Issue requests on the cycles after each `valid` -> each `valid` comes 1 cycle after its `request`; `busy` high for exactly 1 cycle per transaction.
- Reset abort:
  - Store 32'hCAFEF00D to 8'h40 with LATENCY=4; drop `rst` at cycle +2 -> no `valid`, all outputs 0.
  - After reset, load 8'h40 returns the old contents.
  - Separately, store 32'h600DF00D to 8'h44 with no reset; assert reset afterward; load 8'h44 returns 32'h600DF00D (array retained).
- With `DMEM_RESP_STATS_EN`: 3 stores, 2 loads and 1 null transaction -> `wr_count`=3, `rd_count`=2; a forced 16'hFFFE plus 2 stores -> `wr_count`=16'hFFFF.
